acs_pm_unit: RTL and testbench
==============================

Name: acs_pm_unit

Overview:
- Add-compare-select and path-metric stage for the hard-decision, rate-1/2, K=7 (64-state) Viterbi decoder.
- Sits directly downstream of the branch-metric computation and consumes one received symbol pair per valid cycle.
- Updates all 64 path metrics in parallel.
- Emits one survivor decision bit per state to the traceback memory, plus the current best state and metric.

Parameters:
- K, 7, constraint length; NUM_STATES = 2^(K-1) = 64.
- PM_W, 8, path-metric width in bits.
- G0, 7'b1111001, generator polynomial for code bit c0 (octal 171).
- G1, 7'b1011011, generator polynomial for code bit c1 (octal 133).
- INIT_PM, 2^(PM_W-2), starting metric for every state except state 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  rx_pair and frame_start are valid this cycle.
- frame_start  in  1  re-initialise path metrics (trellis restarts in state 0).
- rx_pair  in  2  hard-decision received pair; [0] pairs with c0, [1] pairs with c1.
- out_valid  out  1  decision, best_state, best_metric and norm_event are valid.
- decision  out  NUM_STATES  survivor bit per state; 1 = odd predecessor chosen.
- best_state  out  K-1  index of the minimum new path metric.
- best_metric  out  PM_W  value of that minimum.
- norm_event  out  1  normalisation was applied in this update.

Behaviour:
- Trellis convention:
  - State s is the last K-1 input bits, newest in the MSB.
  - Input u moves state p to {u, p[K-2:1]}.
  - The predecessors of state n are p0 = {n[K-3:0],0} and p1 = {n[K-3:0],1}; the input is u = n[K-2].
- Encoder word: r = {u, p}, with r[6] the newest bit.
  - c0 = ^(r & G0), c1 = ^(r & G1).
- Branch metric: BM = popcount(rx_pair ^ {c1,c0}), range 0..2.
  - Computed internally for both predecessors of every state.
- ACS per state n:
  - m0 = PM[p0] + BM0, m1 = PM[p1] + BM1.
  - New PM[n] = m1 and decision[n] = 1 only if m1 < m0. A tie selects p0 and sets decision = 0.
- Normalisation:
  - If every current PM has its MSB set, all current PMs have the MSB cleared (subtract 2^(PW-1)) before the add, and norm_event = 1.
  - Adds are PM_W bits wide and never wrap; the parameter choice guarantees metric spread ≤ 2(K-1) < 2^(PM_W-2).
- Latency: one cycle.
  - in_valid at cycle t → PM registers, decision, best_state, best_metric and norm_event updated and out_valid = 1 at t+1.
  - With in_valid = 0: out_valid = 0 next cycle, PMs and all data outputs hold.
- best_state / best_metric:
  - Minimum over the 64 new PMs; on a tie the lowest index wins.
  - Registered together with decision.
- Reset (rst = 1, takes priority over everything):
  - PM[0] = 0, PM[1..63] = INIT_PM.
  - out_valid = 0, decision = 0, best_state = 0, best_metric = 0, norm_event = 0.
  - Reset mid-stream discards any in-flight update; no out_valid the following cycle.
- frame_start:
  - With in_valid = 1: the update uses the initialised metric set (PM[0]=0, others INIT_PM) in place of the stored PMs, and produces out_valid next cycle normally.
  - With in_valid = 0: PMs re-initialise, out_valid = 0, other outputs hold.
- No back-pressure: an input is accepted on every cycle that in_valid is high.

Test Plan:
- Reset, then ten rx_pair = 00 with in_valid held:
  - Every cycle after the first input: out_valid = 1, best_state = 0, best_metric = 0, decision[0] = 0.
  - PM[0] stays 0.
- Reset, then a single rx_pair = 01:
  - New PM[0] = 1 and new PM[32] = 1 (branch 0→32 emits 11).
  - best_state = 0 (tie resolved to the lowest index), best_metric = 1.
- Encode a random 200-bit message with G0/G1, flip one bit every 8 symbols, and apply the result:
  - decision and best_state match the bit-exact software ACS model every cycle.
- Same stimulus with PM_W = 6 (INIT_PM = 16), running until norm_event = 1:
  - On that cycle every PM is 32 lower than in an unnormalised model.
  - The decision stream is identical to the PM_W = 8 run.
- Apply in_valid gaps of 1–5 cycles and assert frame_start mid-stream, both with and without in_valid:
  - No out_valid on idle cycles, outputs hold.
  - After frame_start, metrics restart from PM[0]=0 / INIT_PM.
- Assert rst for one cycle during a continuous stream:
  - The next cycle has out_valid = 0 and all outputs zero.
  - The following symbol processes from the initialised metrics.

Source files
------------

// File: rtl/acs_pm_unit.sv
// Add-compare-select and path-metric stage for a rate-1/2 hard-decision Viterbi decoder.
// All 2^(K-1) states update in parallel; one symbol pair per valid cycle, one cycle latency.
module acs_pm_unit #(
   parameter int            K    = 7,
   parameter int            PM_W = 8,
   parameter logic [K-1:0]  G0   = 7'b1111001,
   parameter logic [K-1:0]  G1   = 7'b1011011
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    frame_start,
   input  logic [1:0]              rx_pair,
   output logic                    out_valid,
   output logic [(1<<(K-1))-1:0]   decision,
   output logic [K-2:0]            best_state,
   output logic [PM_W-1:0]         best_metric,
   output logic                    norm_event
);

   localparam int NS = 1 << (K-1);
   localparam int SW = K-1;
   localparam logic [PM_W-1:0] INIT_PM = {2'b01, {(PM_W-2){1'b0}}};

   logic [PM_W-1:0] pm_q    [NS];
   logic [PM_W-1:0] pm_d    [NS];
   logic [PM_W-1:0] base_pm [NS];
   logic [PM_W-1:0] adj_pm  [NS];
   logic            all_msb;
   logic [NS-1:0]   decision_q, decision_d;
   logic [SW-1:0]   best_state_q, best_state_d;
   logic [PM_W-1:0] best_metric_q, best_metric_d;
   logic            out_valid_q, norm_event_q;

   function automatic logic [PM_W-1:0] init_pm(input int idx);
      return (idx == 0) ? '0 : INIT_PM;
   endfunction

   // A frame start swaps in the initial metric set before normalisation and the adds.
   always_comb begin
      all_msb = 1'b1;
      for (int i = 0; i < NS; i++) begin
         base_pm[i] = frame_start ? init_pm(i) : pm_q[i];
         all_msb    = all_msb & base_pm[i][PM_W-1];
      end
      for (int i = 0; i < NS; i++) begin
         adj_pm[i] = all_msb ? {1'b0, base_pm[i][PM_W-2:0]} : base_pm[i];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NS; gi++) begin : g_acs
         // Code bits of both incoming branches are fixed per state, so they fold to constants.
         localparam int           P0 = (2 * gi) % NS;
         localparam int           U  = gi / (NS / 2);
         localparam logic [K-1:0] R0 = K'(U * NS + P0);
         localparam logic [K-1:0] R1 = K'(U * NS + P0 + 1);
         localparam logic [1:0]   C0 = {^(R0 & G1), ^(R0 & G0)};
         localparam logic [1:0]   C1 = {^(R1 & G1), ^(R1 & G0)};

         logic [1:0]      x0, x1, bm0, bm1;
         logic [PM_W-1:0] m0, m1;

         assign x0  = rx_pair ^ C0;
         assign x1  = rx_pair ^ C1;
         assign bm0 = {x0[1] & x0[0], x0[1] ^ x0[0]};
         assign bm1 = {x1[1] & x1[0], x1[1] ^ x1[0]};
         assign m0  = adj_pm[P0]     + {{(PM_W-2){1'b0}}, bm0};
         assign m1  = adj_pm[P0 + 1] + {{(PM_W-2){1'b0}}, bm1};
         assign decision_d[gi] = (m1 < m0);
         assign pm_d[gi]       = (m1 < m0) ? m1 : m0;
      end
   endgenerate

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      best_state_d  = '0;
      best_metric_d = pm_d[0];
      for (int i = 1; i < NS; i++) begin
         if (pm_d[i] < best_metric_d) begin
            best_metric_d = pm_d[i];
            best_state_d  = SW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NS; i++) pm_q[i] <= init_pm(i);
         out_valid_q   <= 1'b0;
         decision_q    <= '0;
         best_state_q  <= '0;
         best_metric_q <= '0;
         norm_event_q  <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < NS; i++) pm_q[i] <= pm_d[i];
            decision_q    <= decision_d;
            best_state_q  <= best_state_d;
            best_metric_q <= best_metric_d;
            norm_event_q  <= all_msb;
         end else if (frame_start) begin
            for (int i = 0; i < NS; i++) pm_q[i] <= init_pm(i);
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign decision    = decision_q;
   assign best_state  = best_state_q;
   assign best_metric = best_metric_q;
   assign norm_event  = norm_event_q;

endmodule

// File: tb/tb_acs_pm_unit.sv
// Directed bench for acs_pm_unit: an 8-bit and a 6-bit metric instance share one stimulus
// stream and are compared against a forward-trellis reference model plus hand-derived values.
module tb_acs_pm_unit;

   localparam logic [6:0] G0 = 7'b1111001;
   localparam logic [6:0] G1 = 7'b1011011;

   typedef int pm_t [64];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        frame_start = 1'b0;
   logic [1:0]  rx_pair = 2'b00;

   logic        ov8, ne8, ov6, ne6;
   logic [63:0] dec8, dec6;
   logic [5:0]  bs8, bs6;
   logic [7:0]  bm8;
   logic [5:0]  bm6;

   int checks = 0;
   int errors = 0;

   pm_t         mp8, mp6, mpu;
   int          nnorm6;
   bit          norm_seen = 1'b0;
   logic        e_valid;
   logic [63:0] e_dec8, e_dec6, e_decu;
   int          e_bs8, e_bm8, e_bs6, e_bm6, e_bsu, e_bmu;
   bit          e_n8, e_n6, e_nu;
   logic [5:0]  enc = 6'd0;

   always #5 clk = ~clk;

   acs_pm_unit dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start), .rx_pair(rx_pair),
      .out_valid(ov8), .decision(dec8), .best_state(bs8), .best_metric(bm8), .norm_event(ne8)
   );

   acs_pm_unit #(.PM_W(6)) dut6 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start), .rx_pair(rx_pair),
      .out_valid(ov6), .decision(dec6), .best_state(bs6), .best_metric(bm6), .norm_event(ne6)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Forward view: walk every predecessor and both inputs, keeping the even (p0) branch on ties.
   task automatic model_acs(input pm_t old, input logic [1:0] rx, input int w, output pm_t nw,
                            output logic [63:0] dec, output int bs, output int bm, output bit nrm);
      pm_t        a;
      int         half, n, cand, bmv;
      logic [6:0] r;
      logic       c0, c1;
      half = (w > 0) ? (1 << (w - 1)) : 0;
      nrm  = (w > 0);
      for (int p = 0; p < 64; p++) if (old[p] < half) nrm = 1'b0;
      for (int p = 0; p < 64; p++) a[p] = nrm ? old[p] - half : old[p];
      dec = '0;
      for (int p = 0; p < 64; p++) begin
         for (int u = 0; u < 2; u++) begin
            n    = u * 32 + p / 2;
            r    = 7'(u * 64 + p);
            c0   = ^(r & G0);
            c1   = ^(r & G1);
            bmv  = int'(rx[0] ^ c0) + int'(rx[1] ^ c1);
            cand = a[p] + bmv;
            if (p % 2 == 0) begin
               nw[n]  = cand;
               dec[n] = 1'b0;
            end else if (cand < nw[n]) begin
               nw[n]  = cand;
               dec[n] = 1'b1;
            end
         end
      end
      bs = 0;
      bm = nw[0];
      for (int i = 1; i < 64; i++) if (nw[i] < bm) begin bm = nw[i]; bs = i; end
   endtask

   task automatic init_models();
      for (int i = 0; i < 64; i++) begin
         mp8[i] = (i == 0) ? 0 : 64;
         mp6[i] = (i == 0) ? 0 : 16;
         mpu[i] = (i == 0) ? 0 : 16;
      end
      nnorm6 = 0;
   endtask

   function automatic logic [1:0] enc_sym(input logic u, input logic [5:0] st);
      logic [6:0] r;
      r = {u, st};
      return {^(r & G1), ^(r & G0)};
   endfunction

   // One clock: drive, advance the model, then compare every output of both instances.
   task automatic step(input bit v, input bit fs, input logic [1:0] rx, input bit r);
      in_valid = v; frame_start = fs; rx_pair = rx; rst = r;
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (r) begin
         init_models();
         e_valid = 1'b0;
         e_dec8 = '0; e_bs8 = 0; e_bm8 = 0; e_n8 = 1'b0;
         e_dec6 = '0; e_bs6 = 0; e_bm6 = 0; e_n6 = 1'b0;
      end else begin
         e_valid = v;
         if (fs) init_models();
         if (v) begin
            model_acs(mp8, rx, 8, mp8, e_dec8, e_bs8, e_bm8, e_n8);
            model_acs(mp6, rx, 6, mp6, e_dec6, e_bs6, e_bm6, e_n6);
            model_acs(mpu, rx, 0, mpu, e_decu, e_bsu, e_bmu, e_nu);
            if (e_n6) nnorm6++;
            chk("pm6_vs_unnorm", 64'(bm6), 64'(e_bmu - 32 * nnorm6));
            chk("dec6_vs_pm8_run", dec6, e_dec8);
         end
      end
      if (ne6 === 1'b1) norm_seen = 1'b1;
      chk("out_valid8", 64'(ov8), 64'(e_valid));
      chk("decision8", dec8, e_dec8);
      chk("best_state8", 64'(bs8), 64'(e_bs8));
      chk("best_metric8", 64'(bm8), 64'(e_bm8));
      chk("norm_event8", 64'(ne8), 64'(e_n8));
      chk("out_valid6", 64'(ov6), 64'(e_valid));
      chk("decision6", dec6, e_dec6);
      chk("best_state6", 64'(bs6), 64'(e_bs6));
      chk("best_metric6", 64'(bm6), 64'(e_bm6));
      chk("norm_event6", 64'(ne6), 64'(e_n6));
   endtask

   task automatic send_msg_sym(input int i, input int flip_every);
      logic       u;
      logic [1:0] sym;
      u   = 1'($urandom_range(0, 1));
      sym = enc_sym(u, enc);
      enc = {u, enc[5:1]};
      if (i % flip_every == flip_every - 1) sym = sym ^ (((i / flip_every) % 2 == 0) ? 2'b01 : 2'b10);
      step(1'b1, 1'b0, sym, 1'b0);
   endtask

   int gaps [5] = '{1, 2, 3, 4, 5};

   initial begin
      // Reset state
      step(1'b0, 1'b0, 2'b00, 1'b1);
      chk("reset_out_valid", 64'(ov8), 64'd0);
      chk("reset_best_metric", 64'(bm8), 64'd0);

      // All-zero received stream stays on the zero path with metric 0
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 2'b00, 1'b0);
         chk("zeros_best_state", 64'(bs8), 64'd0);
         chk("zeros_best_metric", 64'(bm8), 64'd0);
         chk("zeros_dec0", 64'(dec8[0]), 64'd0);
      end

      // Single 01: states 0 and 32 both reach metric 1, lowest index wins
      step(1'b0, 1'b0, 2'b00, 1'b1);
      step(1'b1, 1'b0, 2'b01, 1'b0);
      chk("one_best_state", 64'(bs8), 64'd0);
      chk("one_best_metric", 64'(bm8), 64'd1);
      chk("one_dec32", 64'(dec8[32]), 64'd0);

      // Encoded random message with periodic single-bit errors, long enough to force normalisation
      step(1'b0, 1'b0, 2'b00, 1'b1);
      enc = 6'd0;
      for (int i = 0; i < 200; i++) send_msg_sym(i, 8);
      for (int i = 0; i < 200; i++) send_msg_sym(i, 4);
      chk("norm_seen6", 64'(norm_seen), 64'd1);

      // Idle gaps with changing rx_pair: outputs must hold
      for (int g = 0; g < 5; g++) begin
         send_msg_sym(g, 8);
         for (int j = 0; j < gaps[g]; j++) step(1'b0, 1'b0, 2'(j), 1'b0);
      end

      // frame_start without in_valid, then a symbol from the initial metrics
      step(1'b0, 1'b1, 2'b11, 1'b0);
      chk("fs_idle_out_valid", 64'(ov8), 64'd0);
      step(1'b0, 1'b0, 2'b10, 1'b0);
      step(1'b1, 1'b0, 2'b01, 1'b0);
      chk("fs_idle_best_metric", 64'(bm8), 64'd1);
      chk("fs_idle_best_state", 64'(bs8), 64'd0);

      // frame_start with in_valid mid-stream
      enc = 6'd0;
      for (int i = 0; i < 6; i++) send_msg_sym(i, 3);
      step(1'b1, 1'b1, 2'b00, 1'b0);
      chk("fs_valid_best_metric", 64'(bm8), 64'd0);
      chk("fs_valid_best_state", 64'(bs8), 64'd0);
      enc = 6'd0;
      for (int i = 0; i < 4; i++) send_msg_sym(i, 2);

      // One-cycle reset during a continuous stream
      step(1'b1, 1'b0, 2'b10, 1'b1);
      chk("midrst_out_valid", 64'(ov8), 64'd0);
      chk("midrst_decision", dec8, 64'd0);
      chk("midrst_best_metric", 64'(bm8), 64'd0);
      step(1'b1, 1'b0, 2'b01, 1'b0);
      chk("midrst_next_best_metric", 64'(bm8), 64'd1);
      chk("midrst_next_best_state", 64'(bs8), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
